enemy_controller: RTL



---
 rtl/game_pkg.sv | 27 ++
 rtl/enemy_controller_if.sv | 28 ++
 rtl/enemy_unit.sv | 107 ++++++++++
 rtl/enemy_controller.sv | 64 ++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, defaults and helpers for the playfield game logic.
package game_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    MOVE_POS,
    MOVE_NEG,
    DWELL_HI,
    DWELL_LO
  } enemy_state_t;

  localparam int DEF_ENEMY_R    = 6;
  localparam int DEF_X_MIN      = 112;
  localparam int DEF_X_MAX      = 528;
  localparam int DEF_LANE_PITCH = 32;

  function automatic logic [10:0] abs_diff(
    input coord_t a,
    input coord_t b
  );
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[10] ? 11'(~d + 11'd1) : d;
  endfunction

endpackage

// File: rtl/enemy_controller_if.sv
// Pixel, player and frame signals between game logic and enemy block.
interface enemy_controller_if;
  import game_pkg::*;

  logic   frame_clk;
  logic   restart;
  coord_t DrawX;
  coord_t DrawY;
  coord_t PlayerX;
  coord_t PlayerY;
  coord_t Player_size;
  logic   print_enemy;
  logic   player_hit;

  modport master (
    output frame_clk, restart,
    output DrawX, DrawY,
    output PlayerX, PlayerY, Player_size,
    input  print_enemy, player_hit
  );

  modport slave (
    input  frame_clk, restart,
    input  DrawX, DrawY,
    input  PlayerX, PlayerY, Player_size,
    output print_enemy, player_hit
  );
endinterface

// File: rtl/enemy_unit.sv
// One patrolling enemy: motion FSM, disc pixel test, player overlap test.
module enemy_unit
  import game_pkg::*;
#(
  parameter coord_t Y_POS        = 10'd176,
  parameter bit     START_NEG    = 1'b0,
  parameter int     ENEMY_R      = DEF_ENEMY_R,
  parameter int     SPEED        = 2,
  parameter int     X_MIN        = DEF_X_MIN,
  parameter int     X_MAX        = DEF_X_MAX,
  parameter int     PAUSE_FRAMES = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick,
  input  logic   restart,
  input  coord_t draw_x,
  input  coord_t draw_y,
  input  coord_t player_x,
  input  coord_t player_y,
  input  coord_t player_size,
  output logic   in_disc,
  output logic   hit
);

  localparam int CW =
    PAUSE_FRAMES > 0 ? $clog2(PAUSE_FRAMES + 1) : 1;
  localparam enemy_state_t INIT_ST =
    START_NEG ? MOVE_NEG : MOVE_POS;
  localparam coord_t INIT_X =
    START_NEG ? coord_t'(X_MAX) : coord_t'(X_MIN);
  localparam logic [21:0] R2 = 22'(ENEMY_R * ENEMY_R);

  enemy_state_t   state, state_nx;
  coord_t         x, x_nx;
  logic [CW-1:0]  cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_ST;
      x     <= INIT_X;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    cnt_nx   = cnt;
    if (restart) begin
      state_nx = INIT_ST;
      x_nx     = INIT_X;
      cnt_nx   = '0;
    end else if (tick) begin
      unique case (state)
        MOVE_POS: begin
          if ({1'b0, x} + 11'(SPEED) >= 11'(X_MAX)) begin
            x_nx     = coord_t'(X_MAX);
            state_nx = DWELL_HI;
            cnt_nx   = CW'(PAUSE_FRAMES);
          end else begin
            x_nx = x + coord_t'(SPEED);
          end
        end
        MOVE_NEG: begin
          if ({1'b0, x} <= 11'(X_MIN + SPEED)) begin
            x_nx     = coord_t'(X_MIN);
            state_nx = DWELL_LO;
            cnt_nx   = CW'(PAUSE_FRAMES);
          end else begin
            x_nx = x - coord_t'(SPEED);
          end
        end
        DWELL_HI, DWELL_LO: begin
          // Leaving a dwell consumes the tick; no move on it.
          if (cnt <= CW'(1)) begin
            cnt_nx   = '0;
            state_nx = (state == DWELL_HI) ? MOVE_NEG : MOVE_POS;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [10:0] dxa, dya, pxa, pya, lim;
  logic [21:0] dist2;

  always_comb begin
    dxa   = abs_diff(draw_x, x);
    dya   = abs_diff(draw_y, Y_POS);
    dist2 = {11'd0, dxa} * {11'd0, dxa}
          + {11'd0, dya} * {11'd0, dya};
    in_disc = (dist2 <= R2);
    pxa = abs_diff(player_x, x);
    pya = abs_diff(player_y, Y_POS);
    lim = 11'(ENEMY_R) + {2'b00, player_size[9:1]};
    hit = (pxa <= lim) && (pya <= lim);
  end

endmodule

// File: rtl/enemy_controller.sv
// Enemy array: frame tick detection, per-enemy units, merged outputs.
module enemy_controller
  import game_pkg::*;
#(
  parameter int N_ENEMY      = 4,
  parameter int ENEMY_R      = DEF_ENEMY_R,
  parameter int SPEED        = 2,
  parameter int X_MIN        = DEF_X_MIN,
  parameter int X_MAX        = DEF_X_MAX,
  parameter int Y0           = 176,
  parameter int LANE_PITCH   = DEF_LANE_PITCH,
  parameter int PAUSE_FRAMES = 8
) (
  input logic                Clk,
  input logic                Reset_n,
  enemy_controller_if.slave  bus
);

  logic frame_q, armed, hit_q, tick;
  logic [N_ENEMY-1:0] in_disc, hits;

  // A frame_clk already high at reset release must fall before it counts.
  assign tick = bus.frame_clk & ~frame_q & armed;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      armed   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      frame_q <= bus.frame_clk;
      if (!bus.frame_clk) armed <= 1'b1;
      hit_q <= tick & ~bus.restart & (|hits);
    end
  end

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    enemy_unit #(
      .Y_POS        (coord_t'(Y0 + i * LANE_PITCH)),
      .START_NEG    (bit'(i % 2)),
      .ENEMY_R      (ENEMY_R),
      .SPEED        (SPEED),
      .X_MIN        (X_MIN),
      .X_MAX        (X_MAX),
      .PAUSE_FRAMES (PAUSE_FRAMES)
    ) u_enemy (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .tick        (tick),
      .restart     (bus.restart),
      .draw_x      (bus.DrawX),
      .draw_y      (bus.DrawY),
      .player_x    (bus.PlayerX),
      .player_y    (bus.PlayerY),
      .player_size (bus.Player_size),
      .in_disc     (in_disc[i]),
      .hit         (hits[i])
    );
  end

  assign bus.print_enemy = |in_disc;
  assign bus.player_hit  = hit_q;

endmodule
